// File: rtl/adder_tree_scheduler_pkg.sv
// Shared widths, reset constants and tag type for the adder-tree scheduler.
package adder_tree_scheduler_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned REQ_BITS     = 2;
  localparam int unsigned DIN_WIDTH    = 32;
  localparam int unsigned DOUT_WIDTH   = 7;
  localparam int unsigned TREE_LATENCY = 3;
  localparam int unsigned MAX_OUT      = 4;
  localparam int unsigned CNT_BITS     = 4;
  localparam int unsigned TAG_BITS     = REQ_BITS + 1;

  // Pointer resets to the last index so requester 0 wins first.
  localparam logic [REQ_BITS-1:0] LAST_GRANT_RST = REQ_BITS'(NUM_REQ - 1);

  typedef struct packed {
    logic                vld;
    logic [REQ_BITS-1:0] idx;
  } tag_t;

endpackage

// File: rtl/adder_tree_scheduler_if.sv
// Requester lanes, tree issue/return path and result bus of the scheduler.
interface adder_tree_scheduler_if;
  import adder_tree_scheduler_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DIN_WIDTH-1:0]         tree_din;
  logic                         tree_sync;
  logic [DOUT_WIDTH-1:0]        tree_dout;
  logic                         tree_sync_out;
  logic [NUM_REQ-1:0]           res_valid;
  logic [DOUT_WIDTH-1:0]        res_data;
  logic                         sync_err;

  modport master (
    output req_valid, req_data, tree_dout, tree_sync_out,
    input  req_ready, tree_din, tree_sync, res_valid, res_data, sync_err
  );

  modport slave (
    input  req_valid, req_data, tree_dout, tree_sync_out,
    output req_ready, tree_din, tree_sync, res_valid, res_data, sync_err
  );

endinterface

// File: rtl/adder_tree_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index after the last grant wins.
module adder_tree_scheduler_rr_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned ReqBits = 2
) (
  input  logic [NumReq-1:0]  i_eligible,
  input  logic [ReqBits-1:0] i_last_grant,
  output logic [NumReq-1:0]  o_grant,
  output logic [ReqBits-1:0] o_idx,
  output logic               o_any
);

  always_comb begin : p_arb
    logic [ReqBits-1:0] w_cand;
    w_cand  = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      w_cand = ReqBits'((32'(i_last_grant) + k) % NumReq);
      if (!o_any && i_eligible[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/adder_tree_scheduler.sv
// Shares one pipelined adder tree between NUM_REQ requesters; sums are routed back by a
// tag delay line matched to the tree latency.
module adder_tree_scheduler
  import adder_tree_scheduler_pkg::*;
#(
  parameter int unsigned TreeLatency = TREE_LATENCY,
  parameter int unsigned MaxOut      = MAX_OUT
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  adder_tree_scheduler_if.slave io_bus
);

  localparam int unsigned GuardBits = (TreeLatency > 0) ? $clog2(TreeLatency + 1) : 1;

  logic [NUM_REQ-1:0]    w_eligible;
  logic [NUM_REQ-1:0]    w_grant;
  logic [REQ_BITS-1:0]   w_grant_idx;
  logic                  w_any;
  logic                  w_xfer;
  tag_t                  w_tag_aligned;

  logic [REQ_BITS-1:0]   r_last_grant;
  logic [CNT_BITS-1:0]   r_out_cnt [NUM_REQ];
  tag_t                  r_tag [TreeLatency+1];
  logic [DIN_WIDTH-1:0]  r_tree_din;
  logic                  r_tree_sync;
  logic [NUM_REQ-1:0]    r_res_valid;
  logic [DOUT_WIDTH-1:0] r_res_data;
  logic                  r_sync_err;
  logic [GuardBits-1:0]  r_guard;

  always_comb begin
    w_eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = io_bus.req_valid[i] && (r_out_cnt[i] < CNT_BITS'(MaxOut));
    end
  end

  adder_tree_scheduler_rr_arbiter #(
    .NumReq  (NUM_REQ),
    .ReqBits (REQ_BITS)
  ) u_arb (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_grant_idx),
    .o_any        (w_any)
  );

  assign io_bus.req_ready = i_rst_n ? w_grant : '0;
  assign w_xfer           = i_rst_n && w_any;
  // Stage 0 is aligned with tree_sync, the last stage with tree_sync_out.
  assign w_tag_aligned    = r_tag[TreeLatency];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tree_din   <= '0;
      r_tree_sync  <= 1'b0;
      r_last_grant <= LAST_GRANT_RST;
      for (int unsigned k = 0; k <= TreeLatency; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tree_sync  <= w_xfer;
      r_tag[0].vld <= w_xfer;
      r_tag[0].idx <= w_grant_idx;
      for (int unsigned k = 1; k <= TreeLatency; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      if (w_xfer) begin
        r_tree_din   <= io_bus.req_data[w_grant_idx*DIN_WIDTH +: DIN_WIDTH];
        r_last_grant <= w_grant_idx;
      end
    end
  end

  // After reset the tree may still emit syncs for discarded tags; ignore them for one latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
      r_sync_err  <= 1'b0;
      r_guard     <= GuardBits'(TreeLatency);
    end else begin
      r_res_valid <= '0;
      if (w_tag_aligned.vld) begin
        r_res_valid[w_tag_aligned.idx] <= 1'b1;
        r_res_data                     <= io_bus.tree_dout;
      end
      if (r_guard != '0) begin
        r_guard <= r_guard - GuardBits'(1);
      end else if (w_tag_aligned.vld != io_bus.tree_sync_out) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_out_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_xfer && w_grant[i] && !r_res_valid[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] + CNT_BITS'(1);
        end else if (!(w_xfer && w_grant[i]) && r_res_valid[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] - CNT_BITS'(1);
        end
      end
    end
  end

  assign io_bus.tree_din  = r_tree_din;
  assign io_bus.tree_sync = r_tree_sync;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_data  = r_res_data;
  assign io_bus.sync_err  = r_sync_err;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Random and directed stimulus for adder_tree_scheduler against a queue-based issue/result model.
module tb_adder_tree_scheduler;
  import adder_tree_scheduler_pkg::*;

  localparam int L      = TREE_LATENCY;
  localparam int MaxCyc = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic inj   = 1'b0;

  adder_tree_scheduler_if bus ();

  adder_tree_scheduler #(
    .TreeLatency (L),
    .MaxOut      (MAX_OUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DOUT_WIDTH-1:0] nib_sum(input logic [DIN_WIDTH-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < DIN_WIDTH / 4; k++) s += int'(v[k*4 +: 4]);
    return DOUT_WIDTH'(s);
  endfunction

  // Stand-in tree: sums 4-bit samples, L registered stages, not reset.
  logic [DIN_WIDTH-1:0] tr_din [L] = '{default: '0};
  logic                 tr_sync [L] = '{default: 1'b0};
  always @(posedge clk) begin
    tr_din[0]  <= bus.tree_din;
    tr_sync[0] <= bus.tree_sync;
    for (int k = 1; k < L; k++) begin
      tr_din[k]  <= tr_din[k-1];
      tr_sync[k] <= tr_sync[k-1];
    end
  end
  assign bus.tree_dout     = nib_sum(tr_din[L-1]);
  assign bus.tree_sync_out = tr_sync[L-1] | inj;

  typedef struct {
    int                    due;
    int                    idx;
    logic [DOUT_WIDTH-1:0] sum;
  } pend_t;

  pend_t                 q[$];
  bit                    gh [MaxCyc];
  int                    cyc = 0;
  int                    rel = 0;
  int                    last_g = NUM_REQ - 1;
  logic [DIN_WIDTH-1:0]  exp_din = '0;
  logic                  exp_sync = 1'b0;
  logic [DOUT_WIDTH-1:0] exp_rdata = '0;
  logic                  exp_err = 1'b0;
  int                    n_cmp = 0;
  int                    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, check every output against the model, then advance the model.
  task automatic step(input logic rstn_v, input logic [NUM_REQ-1:0] v,
                      input logic [NUM_REQ*DIN_WIDTH-1:0] d, input logic inj_v);
    int                    cnt [NUM_REQ];
    int                    win;
    int                    c;
    logic [NUM_REQ-1:0]    exp_rv;
    logic [NUM_REQ-1:0]    exp_rdy;
    logic [DOUT_WIDTH-1:0] exp_rd;
    logic                  sout;
    logic                  tvld;
    @(negedge clk);
    rst_n         = rstn_v;
    bus.req_valid = v;
    bus.req_data  = d;
    inj           = inj_v;
    #1;
    while (q.size() > 0 && q[0].due < cyc) q.delete(0);
    foreach (cnt[i]) cnt[i] = 0;
    foreach (q[j]) cnt[q[j].idx]++;
    win = -1;
    if (rstn_v) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (last_g + k) % NUM_REQ;
        if (win < 0 && v[c] && cnt[c] < MAX_OUT) win = c;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_rv = '0;
    exp_rd = exp_rdata;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].idx] = 1'b1;
      exp_rd           = q[0].sum;
    end
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("res_valid", bus.res_valid, exp_rv);
    chk("res_data", bus.res_data, exp_rd);
    chk("tree_sync", bus.tree_sync, exp_sync);
    chk("tree_din", bus.tree_din, exp_din);
    chk("sync_err", bus.sync_err, exp_err);
    sout = ((cyc - L - 1 >= 0) && gh[cyc-L-1]) | inj_v;
    tvld = (cyc - L - 1 >= rel) && gh[cyc-L-1];
    if (!rstn_v) begin
      q.delete();
      last_g    = NUM_REQ - 1;
      exp_din   = '0;
      exp_sync  = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      rel       = cyc + 1;
    end else begin
      exp_rdata = exp_rd;
      if (cyc >= rel + L && sout != tvld) exp_err = 1'b1;
      exp_sync = (win >= 0);
      if (win >= 0) begin
        gh[cyc] = 1'b1;
        last_g  = win;
        exp_din = d[win*DIN_WIDTH +: DIN_WIDTH];
        q.push_back('{due: cyc + L + 2, idx: win, sum: nib_sum(exp_din)});
      end
    end
    cyc++;
  endtask

  function automatic logic [NUM_REQ*DIN_WIDTH-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b1, '0, rnd_data(), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, rnd_data(), 1'b0);
  endtask

  initial begin
    logic [NUM_REQ*DIN_WIDTH-1:0] d;
    logic [7:0]                   pat;
    logic [NUM_REQ-1:0]           rr_exp;
    logic [NUM_REQ-1:0]           v;
    int                           seen;
    int                           dens;

    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset held with all lanes valid: no grants, registered outputs cleared.
    repeat (3) step(1'b0, '1, rnd_data(), 1'b0);
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_res_valid", bus.res_valid, 4'b0000);
    chk("rst_tree_sync", bus.tree_sync, 1'b0);
    chk("rst_tree_din", bus.tree_din, 32'h0);
    chk("rst_sync_err", bus.sync_err, 1'b0);

    // Single requester 0.
    d = '0;
    d[31:0] = 32'h0123_4567;
    step(1'b1, 4'b0001, d, 1'b0);
    chk("s1_ready", bus.req_ready, 4'b0001);
    idle(1);
    chk("s1_tree_sync", bus.tree_sync, 1'b1);
    chk("s1_tree_din", bus.tree_din, 32'h0123_4567);
    idle(3);
    idle(1);
    chk("s1_res_valid", bus.res_valid, 4'b0001);
    chk("s1_res_data", bus.res_data, 7'd28);
    idle(4);

    // Round-robin with all lanes busy.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 4'b1111, rnd_data(), 1'b0);
      rr_exp = '0;
      rr_exp[k % NUM_REQ] = 1'b1;
      chk("rr_order", bus.req_ready, rr_exp);
    end
    idle(8);

    // Outstanding limit on requester 2.
    do_reset();
    pat = 8'b1100_1111;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0100, rnd_data(), 1'b0);
      chk("limit_ready2", bus.req_ready[2], pat[k]);
    end
    idle(10);

    // Grant and result on requester 1 in the same cycle.
    do_reset();
    step(1'b1, 4'b0010, rnd_data(), 1'b0);
    idle(4);
    step(1'b1, 4'b0010, rnd_data(), 1'b0);
    chk("simul_ready", bus.req_ready, 4'b0010);
    chk("simul_res_valid", bus.res_valid, 4'b0010);
    idle(8);

    // Reset with three results in flight.
    do_reset();
    step(1'b1, 4'b0001, rnd_data(), 1'b0);
    step(1'b1, 4'b0010, rnd_data(), 1'b0);
    step(1'b1, 4'b0100, rnd_data(), 1'b0);
    do_reset();
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      if (bus.res_valid != '0) seen++;
    end
    chk("midrst_no_results", 64'(seen), 64'd0);
    chk("midrst_no_err", bus.sync_err, 1'b0);

    // Spurious tree_sync_out with nothing in flight.
    idle(6);
    step(1'b1, '0, rnd_data(), 1'b1);
    idle(1);
    chk("fault_err_set", bus.sync_err, 1'b1);
    idle(3);
    chk("fault_err_sticky", bus.sync_err, 1'b1);
    do_reset();
    idle(1);
    chk("fault_err_cleared", bus.sync_err, 1'b0);

    // Random traffic with occasional resets and sync faults.
    dens = 50;
    for (int k = 0; k < 1500; k++) begin
      if (k % 64 == 0) dens = int'($urandom_range(100));
      v = '0;
      for (int i = 0; i < NUM_REQ; i++) v[i] = ($urandom_range(99) < dens);
      step(($urandom_range(149) != 0), v, rnd_data(), ($urandom_range(299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
